// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-requester ALU arbiter: FSM states, flag bit
// positions and requester IDs.
package alu_arb_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StResp = 2'd2
  } state_e;

  // Bit positions inside the {n,c,z,v} response flag vector
  localparam int unsigned NzcvN = 3;
  localparam int unsigned NzcvC = 2;
  localparam int unsigned NzcvZ = 1;
  localparam int unsigned NzcvV = 0;

  localparam logic IdReq0 = 1'b0;
  localparam logic IdReq1 = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way grant generator. Round-robin by default; fixed priority to requester 0
// when ALU_ARB_FIXED_PRIO_EN is defined.
module rr_arbiter2
  import alu_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

`ifdef ALU_ARB_FIXED_PRIO_EN
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req[0])      gnt = 2'b01;
      else if (req[1]) gnt = 2'b10;
    end
  end
`else
  logic last_grant_q;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      unique case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        // Contention: the requester that did not win last time goes first
        2'b11:   gnt = (last_grant_q == IdReq1) ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  // A grant is always a transfer (ready == grant), so it updates history directly
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= IdReq1;
    end else if (gnt != 2'b00) begin
      last_grant_q <= gnt[1];
    end
  end
`endif

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one combinational ALU between two requesters: accept, execute for one cycle,
// hold a tagged response until consumed. Build option: ALU_ARB_FIXED_PRIO_EN.
module alu_req_arbiter
  import alu_arb_pkg::*;
#(
  parameter int unsigned len  = 4,
  parameter int unsigned OP_W = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  input  logic [OP_W-1:0] req0_op,
  input  logic [len-1:0]  req0_a,
  input  logic [len-1:0]  req0_b,
  output logic            req0_ready,
  input  logic            req1_valid,
  input  logic [OP_W-1:0] req1_op,
  input  logic [len-1:0]  req1_a,
  input  logic [len-1:0]  req1_b,
  output logic            req1_ready,
  output logic [OP_W-1:0] alu_op,
  output logic [len-1:0]  alu_a,
  output logic [len-1:0]  alu_b,
  input  logic [len-1:0]  alu_result,
  input  logic            alu_n,
  input  logic            alu_c,
  input  logic            alu_z,
  input  logic            alu_v,
  output logic            resp_valid,
  output logic            resp_id,
  output logic [len-1:0]  resp_result,
  output logic [3:0]      resp_nzcv,
  input  logic            resp_ready
);

  state_e          state_q, state_d;
  logic [1:0]      gnt;
  logic            arb_en;
  logic [OP_W-1:0] op_q;
  logic [len-1:0]  a_q, b_q;
  logic            id_q;
  logic            resp_valid_q;
  logic            resp_id_q;
  logic [len-1:0]  resp_result_q;
  logic [3:0]      resp_nzcv_q;
  logic [3:0]      alu_nzcv;

  // Gated by rst so nothing is offered while reset is being applied
  assign arb_en = (state_q == StIdle) && !rst;

  rr_arbiter2 u_arb (
    .clk (clk),
    .rst (rst),
    .req ({req1_valid, req0_valid}),
    .en  (arb_en),
    .gnt (gnt)
  );

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];

  always_comb begin
    alu_nzcv        = 4'b0000;
    alu_nzcv[NzcvN] = alu_n;
    alu_nzcv[NzcvC] = alu_c;
    alu_nzcv[NzcvZ] = alu_z;
    alu_nzcv[NzcvV] = alu_v;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (gnt != 2'b00) state_d = StExec;
      StExec:  state_d = StResp;
      StResp:  if (resp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q          <= '0;
      a_q           <= '0;
      b_q           <= '0;
      id_q          <= IdReq0;
      resp_valid_q  <= 1'b0;
      resp_id_q     <= IdReq0;
      resp_result_q <= '0;
      resp_nzcv_q   <= 4'b0000;
    end else begin
      if (gnt[1]) begin
        op_q <= req1_op;
        a_q  <= req1_a;
        b_q  <= req1_b;
        id_q <= IdReq1;
      end else if (gnt[0]) begin
        op_q <= req0_op;
        a_q  <= req0_a;
        b_q  <= req0_b;
        id_q <= IdReq0;
      end
      if (state_q == StExec) begin
        resp_valid_q  <= 1'b1;
        resp_id_q     <= id_q;
        resp_result_q <= alu_result;
        resp_nzcv_q   <= alu_nzcv;
      end else if (state_q == StResp && resp_ready) begin
        resp_valid_q <= 1'b0;
      end
    end
  end

  // Operand registers only change on a transfer, so the ALU inputs hold between operations
  assign alu_op      = op_q;
  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign resp_valid  = resp_valid_q;
  assign resp_id     = resp_id_q;
  assign resp_result = resp_result_q;
  assign resp_nzcv   = resp_nzcv_q;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Self-checking bench for alu_req_arbiter: transaction-level model checked every cycle,
// plus directed vectors with hand-computed results.
module tb_alu_req_arbiter;

`ifdef ALU_ARB_FIXED_PRIO_EN
  localparam bit FixedPrio = 1'b1;
`else
  localparam bit FixedPrio = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid, req0_ready, req1_ready;
  logic [2:0] req0_op, req1_op, alu_op;
  logic [3:0] req0_a, req0_b, req1_a, req1_b, alu_a, alu_b, alu_result;
  logic       alu_n, alu_c, alu_z, alu_v;
  logic       resp_valid, resp_id, resp_ready;
  logic [3:0] resp_result, resp_nzcv;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_req_arbiter #(.len(4), .OP_W(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ready (req1_ready),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .alu_n      (alu_n),
    .alu_c      (alu_c),
    .alu_z      (alu_z),
    .alu_v      (alu_v),
    .resp_valid (resp_valid),
    .resp_id    (resp_id),
    .resp_result(resp_result),
    .resp_nzcv  (resp_nzcv),
    .resp_ready (resp_ready)
  );

  // Stand-in for the nbit ALU family: op 1 = add, op 2 = and, anything else = or.
  // Returns {result[3:0], n, c, z, v}.
  function automatic logic [7:0] alu_fn(input logic [2:0] op, input logic [3:0] a,
                                        input logic [3:0] b);
    logic [4:0] s;
    logic [3:0] r;
    logic       c, v;
    c = 1'b0;
    v = 1'b0;
    case (op)
      3'd1: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[3:0];
        c = s[4];
        v = (a[3] == b[3]) && (r[3] != a[3]);
      end
      3'd2:    r = a & b;
      default: r = a | b;
    endcase
    return {r, r[3], c, (r == 4'd0), v};
  endfunction

  always_comb {alu_result, alu_n, alu_c, alu_z, alu_v} = alu_fn(alu_op, alu_a, alu_b);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  bit         m_busy = 1'b0;
  int         m_age = 0;
  bit         m_last = 1'b1;
  bit         m_chk_rst = 1'b0;
  bit         t_id;
  logic [2:0] t_op;
  logic [3:0] t_a, t_b, t_res, t_nzcv;
  int         dut_grants[$];
  int         resp_seen = 0;

  always @(negedge clk) begin
    int g;
    if (resp_valid) resp_seen++;
    if (req0_valid && req0_ready) dut_grants.push_back(0);
    else if (req1_valid && req1_ready) dut_grants.push_back(1);
    if (m_chk_rst) begin
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_resp_id", 32'(resp_id), 32'd0);
      check("rst_resp_result", 32'(resp_result), 32'd0);
      check("rst_resp_nzcv", 32'(resp_nzcv), 32'd0);
      check("rst_alu_op", 32'(alu_op), 32'd0);
      check("rst_alu_a", 32'(alu_a), 32'd0);
      check("rst_alu_b", 32'(alu_b), 32'd0);
    end
    if (rst) begin
      check("rst_ready0", 32'(req0_ready), 32'd0);
      check("rst_ready1", 32'(req1_ready), 32'd0);
      m_busy    = 1'b0;
      m_last    = 1'b1;
      m_chk_rst = 1'b1;
    end else begin
      m_chk_rst = 1'b0;
      if (!m_busy) begin
        g = -1;
        if (req0_valid && req1_valid) g = (FixedPrio || m_last) ? 0 : 1;
        else if (req0_valid) g = 0;
        else if (req1_valid) g = 1;
        check("idle_ready0", 32'(req0_ready), 32'(g == 0));
        check("idle_ready1", 32'(req1_ready), 32'(g == 1));
        check("idle_resp_valid", 32'(resp_valid), 32'd0);
        if (g >= 0) begin
          m_busy = 1'b1;
          m_age  = 0;
          t_id   = (g == 1);
          t_op   = (g == 1) ? req1_op : req0_op;
          t_a    = (g == 1) ? req1_a : req0_a;
          t_b    = (g == 1) ? req1_b : req0_b;
          {t_res, t_nzcv} = alu_fn(t_op, t_a, t_b);
          m_last = t_id;
        end
      end else if (m_age == 0) begin
        check("exec_ready0", 32'(req0_ready), 32'd0);
        check("exec_ready1", 32'(req1_ready), 32'd0);
        check("exec_resp_valid", 32'(resp_valid), 32'd0);
        check("exec_alu_op", 32'(alu_op), 32'(t_op));
        check("exec_alu_a", 32'(alu_a), 32'(t_a));
        check("exec_alu_b", 32'(alu_b), 32'(t_b));
        m_age = 1;
      end else begin
        check("resp_ready0", 32'(req0_ready), 32'd0);
        check("resp_ready1", 32'(req1_ready), 32'd0);
        check("resp_valid", 32'(resp_valid), 32'd1);
        check("resp_id", 32'(resp_id), 32'(t_id));
        check("resp_result", 32'(resp_result), 32'(t_res));
        check("resp_nzcv", 32'(resp_nzcv), 32'(t_nzcv));
        if (resp_ready) m_busy = 1'b0;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one op, wait for the grant and the response, and pin the response to literals.
  task automatic issue(input bit id, input logic [2:0] op, input logic [3:0] a,
                       input logic [3:0] b, input logic [3:0] exp_res,
                       input logic [3:0] exp_nzcv);
    bit got;
    int lat;
    step();
    if (id) begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
    end else begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
    end
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      got = id ? req1_ready : req0_ready;
    end
    check("issue_grant_seen", 32'(got), 32'd1);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    lat = 0;
    got = 1'b0;
    for (int k = 1; k <= 10 && !got; k++) begin
      @(negedge clk);
      if (resp_valid) begin
        got = 1'b1;
        lat = k;
      end
    end
    check("issue_resp_seen", 32'(got), 32'd1);
    check("issue_latency", 32'(lat), 32'd2);
    check("issue_lit_id", 32'(resp_id), 32'(id));
    check("issue_lit_result", 32'(resp_result), 32'(exp_res));
    check("issue_lit_nzcv", 32'(resp_nzcv), 32'(exp_nzcv));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit         got;
    logic [3:0] held_res, held_nzcv;
    int         seen0;
    int         exp_g[4];
    rst = 1'b1;
    req0_valid = 1'b1; req0_op = 3'd0; req0_a = 4'd2; req0_b = 4'd1;
    req1_valid = 1'b0; req1_op = 3'd0; req1_a = 4'd0; req1_b = 4'd0;
    resp_ready = 1'b1;

    // 1: reset held two cycles with req0 valid
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("t1_ready0_in_rst", 32'(req0_ready), 32'd0);
    check("t1_resp_valid_in_rst", 32'(resp_valid), 32'd0);
    step();
    rst = 1'b0;
    req0_valid = 1'b0;

    // 2: single op, 2|1 = 3
    issue(1'b0, 3'd0, 4'd2, 4'd1, 4'd3, 4'b0000);

    // 3: flags
    issue(1'b1, 3'd0, 4'd0, 4'd0, 4'd0, 4'b0010);
    issue(1'b1, 3'd0, 4'd8, 4'd0, 4'd8, 4'b1000);
    issue(1'b0, 3'd1, 4'd7, 4'd1, 4'd8, 4'b1001);
    issue(1'b0, 3'd1, 4'd15, 4'd1, 4'd0, 4'b0110);
    issue(1'b1, 3'd2, 4'd12, 4'd10, 4'd8, 4'b1000);

    // 4: contention; last grant so far is requester 1
    step();
    dut_grants.delete();
    req0_valid = 1'b1; req0_op = 3'd0; req0_a = 4'd3; req0_b = 4'd3;
    req1_valid = 1'b1; req1_op = 3'd1; req1_a = 4'd7; req1_b = 4'd0;
    repeat (12) step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    exp_g = FixedPrio ? '{0, 0, 0, 0} : '{0, 1, 0, 1};
    check("t4_grant_count", 32'(dut_grants.size()), 32'd4);
    for (int i = 0; i < 4 && i < dut_grants.size(); i++)
      check("t4_grant_order", 32'(dut_grants[i]), 32'(exp_g[i]));
    repeat (4) step();

    // 5: backpressure on the response while requester 1 keeps asking
    resp_ready = 1'b0;
    req0_valid = 1'b1; req0_op = 3'd0; req0_a = 4'd5; req0_b = 4'd2;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      got = req0_ready;
    end
    check("t5_grant_seen", 32'(got), 32'd1);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_op = 3'd0; req1_a = 4'd1; req1_b = 4'd4;
    @(negedge clk);
    @(negedge clk);
    check("t5_resp_valid", 32'(resp_valid), 32'd1);
    held_res  = resp_result;
    held_nzcv = resp_nzcv;
    check("t5_lit_result", 32'(held_res), 32'd7);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t5_hold_valid", 32'(resp_valid), 32'd1);
      check("t5_hold_result", 32'(resp_result), 32'(held_res));
      check("t5_hold_nzcv", 32'(resp_nzcv), 32'(held_nzcv));
      check("t5_no_accept", 32'(req1_ready), 32'd0);
    end
    step();
    resp_ready = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      got = req1_ready;
    end
    check("t5_req1_after_release", 32'(got), 32'd1);
    step();
    req1_valid = 1'b0;
    repeat (4) step();

    // 6: reset while the op is executing
    req0_valid = 1'b1; req0_op = 3'd0; req0_a = 4'd1; req0_b = 4'd1;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      got = req0_ready;
    end
    check("t6_grant_seen", 32'(got), 32'd1);
    step();
    req0_valid = 1'b0;
    rst = 1'b1;
    seen0 = resp_seen;
    step();
    rst = 1'b0;
    repeat (6) step();
    check("t6_no_resp_after_rst", 32'(resp_seen - seen0), 32'd0);
    issue(1'b1, 3'd1, 4'd3, 4'd4, 4'd7, 4'b0000);

    repeat (3) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
